blink_code_scheduler: RTL and testbench

- Shares one status LED between NREQ requesters. Each requester asks the LED to flash a short numeric blink code, for example an error number.
- A round-robin arbiter grants one request at a time.
- The sequencer then plays the granted code as N blinks with fixed on/off times, followed by an inter-code gap.
- Sits between the status/error sources and the board LED pin. It replaces the free-running toggle counter for that pin.

---
 rtl/blink_code_scheduler.sv | 167 ++++++++++++++++
 tb/tb_blink_code_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_code_scheduler.sv
`default_nettype none
// ============================================================================
// blink_code_scheduler: round-robin shares one status LED between requesters,
// each playing an N-blink code followed by an inter-code gap.   Rev 1.0
// ============================================================================

module blink_code_scheduler #(
  parameter int  NREQ     = 4,
  parameter int  ON_TIME  = 50000000,
  parameter int  OFF_TIME = 25000000,
  parameter int  GAP_TIME = 100000000,
  parameter int  CNT_W    = 27,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] code,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [IDW-1:0]    active_id,
  output logic              ledpin
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ON_RELOAD  = CNT_W'(ON_TIME - 1);
  localparam logic [CNT_W-1:0] OFF_RELOAD = CNT_W'(OFF_TIME - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_TIME - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   active_id_q, active_id_d;
  logic             ledpin_q, ledpin_d;

  logic             found_hi;
  logic [IDW-1:0]   idx_hi, idx_any, grant_idx, next_ptr;
  logic [3:0]       code_hi, code_any, grant_code;

  // Descending scan leaves the lowest matching index: idx_hi is the first
  // request at or above the pointer, idx_any the wrap-around fallback.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_any  = '0;
    code_hi  = '0;
    code_any = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_any  = IDW'(i);
        code_any = code[i*4 +: 4];
        if (IDW'(i) >= ptr_q) begin
          found_hi = 1'b1;
          idx_hi   = IDW'(i);
          code_hi  = code[i*4 +: 4];
        end
      end
    end
    grant_idx  = found_hi ? idx_hi  : idx_any;
    grant_code = found_hi ? code_hi : code_any;
    next_ptr   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    ptr_d       = ptr_q;
    ack_d       = '0;
    busy_d      = busy_q;
    active_id_d = active_id_q;
    ledpin_d    = ledpin_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          ack_d       = NREQ'(1) << grant_idx;
          active_id_d = grant_idx;
          ptr_d       = next_ptr;
          remaining_d = grant_code;
          // A zero-length code consumes the grant but never lights the LED.
          if (grant_code != 4'd0) begin
            state_d     = S_ON;
            ledpin_d    = 1'b1;
            busy_d      = 1'b1;
            timer_d     = ON_RELOAD;
            remaining_d = grant_code - 4'd1;
          end
        end
      end
      S_ON: begin
        if (timer_q == '0) begin
          state_d  = S_OFF;
          ledpin_d = 1'b0;
          timer_d  = OFF_RELOAD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_OFF: begin
        if (timer_q == '0) begin
          if (remaining_q != 4'd0) begin
            state_d     = S_ON;
            ledpin_d    = 1'b1;
            timer_d     = ON_RELOAD;
            remaining_d = remaining_q - 4'd1;
          end else begin
            state_d = S_GAP;
            timer_d = GAP_RELOAD;
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      ptr_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
      ledpin_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      active_id_q <= active_id_d;
      ledpin_q    <= ledpin_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;
  assign ledpin    = ledpin_q;

endmodule

`default_nettype wire

// File: tb/tb_blink_code_scheduler.sv
`default_nettype none
// ============================================================================
// tb_blink_code_scheduler: randomized self-checking bench against a
// schedule-level reference model of the blink scheduler.   Rev 1.0
// ============================================================================

module tb_blink_code_scheduler;

  localparam int NREQ = 4;
  localparam int ON   = 4;
  localparam int OFF  = 2;
  localparam int GAP  = 6;
  localparam int P    = ON + OFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] code;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [1:0]        active_id;
  logic              ledpin;

  int checks   = 0;
  int failures = 0;

  // Reference model: a granted code of n blinks is a window of n*P+GAP busy
  // cycles; inside it the LED is lit for the first ON cycles of each period.
  int         m_ptr, m_t, m_total, m_n;
  bit         m_playing;
  logic [3:0] m_ack;
  logic       m_led, m_busy;
  logic [1:0] m_active;

  blink_code_scheduler #(
    .NREQ(NREQ), .ON_TIME(ON), .OFF_TIME(OFF), .GAP_TIME(GAP), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code),
    .ack(ack), .busy(busy), .active_id(active_id), .ledpin(ledpin)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_ptr = 0; m_t = 0; m_total = 0; m_n = 0; m_playing = 0;
    m_ack = '0; m_led = 0; m_busy = 0; m_active = '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_ack = '0;
      if (m_playing) begin
        m_t++;
        if (m_t >= m_total) begin
          m_playing = 0; m_busy = 0; m_led = 0;
        end else begin
          m_led = (m_t < m_n * P) && ((m_t % P) < ON);
        end
      end else if (|req) begin
        int idx;
        idx = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (idx < 0 && req[(m_ptr + k) % NREQ]) idx = (m_ptr + k) % NREQ;
        end
        m_ack    = 4'(1 << idx);
        m_active = 2'(idx);
        m_ptr    = (idx + 1) % NREQ;
        m_n      = int'(code[idx*4 +: 4]);
        if (m_n > 0) begin
          m_playing = 1; m_t = 0; m_total = m_n * P + GAP;
          m_busy = 1; m_led = 1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int ack_index(input logic [NREQ-1:0] a);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (a[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    code  = {4'd1, 4'd2, 4'd0, 4'd1};
    model_reset();
    #2;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({ack, busy, active_id, ledpin} !== 8'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d ack/busy/id/led got=%b/%b/%0d/%b exp=0/0/0/0",
                 c, ack, busy, active_id, ledpin);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      checks++;
      if ({ack, busy, active_id, ledpin} !== {m_ack, m_busy, m_active, m_led}) begin
        failures++;
        $display("FAIL reset_release cyc=%0d ack/busy/id/led got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 c, ack, busy, active_id, ledpin, m_ack, m_busy, m_active, m_led);
      end
      if (c == 0) begin
        checks++;
        if (ack !== 4'b0001) begin
          failures++;
          $display("FAIL reset_first_grant got=%b exp=0001", ack);
        end
      end
      req = req & ~m_ack;
    end
  endtask

  task automatic test_single_code();
    int busy_cnt, led_cnt;
    busy_cnt = 0; led_cnt = 0;
    do_reset();
    code = {4'd0, 4'd0, 4'd0, 4'd3};
    req  = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if ({ack, busy, active_id, ledpin} !== {m_ack, m_busy, m_active, m_led}) begin
        failures++;
        $display("FAIL single_code cyc=%0d ack/busy/id/led got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 c, ack, busy, active_id, ledpin, m_ack, m_busy, m_active, m_led);
      end
      busy_cnt += int'(busy);
      led_cnt  += int'(ledpin);
      req = req & ~m_ack;
    end
    checks++;
    if (busy_cnt != 3 * P + GAP) begin
      failures++;
      $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, 3 * P + GAP);
    end
    checks++;
    if (led_cnt != 3 * ON) begin
      failures++;
      $display("FAIL single_led_len got=%0d exp=%0d", led_cnt, 3 * ON);
    end
  endtask

  task automatic test_simultaneous();
    int order[$];
    do_reset();
    code = {4'd0, 4'd1, 4'd1, 4'd0};
    req  = 4'b0110;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if ({ack, busy, active_id, ledpin} !== {m_ack, m_busy, m_active, m_led}) begin
        failures++;
        $display("FAIL simultaneous cyc=%0d ack/busy/id/led got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 c, ack, busy, active_id, ledpin, m_ack, m_busy, m_active, m_led);
      end
      checks++;
      if ($countones(ack) > 1) begin
        failures++;
        $display("FAIL sim_onehot cyc=%0d got=%b exp=at most one bit", c, ack);
      end
      if (ack != '0) order.push_back(ack_index(ack));
      req = req & ~m_ack;
    end
    checks++;
    if (order.size() != 2 || order[0] != 1 || order[1] != 2) begin
      failures++;
      $display("FAIL sim_order got_count=%0d exp=2 grants ordered 1,2", order.size());
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[4];
    exp_order = '{0, 3, 0, 3};
    do_reset();
    code = {4'd1, 4'd0, 4'd0, 4'd1};
    req  = 4'b1001;
    for (int c = 0; c < 54; c++) begin
      tick();
      checks++;
      if ({ack, busy, active_id, ledpin} !== {m_ack, m_busy, m_active, m_led}) begin
        failures++;
        $display("FAIL round_robin cyc=%0d ack/busy/id/led got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 c, ack, busy, active_id, ledpin, m_ack, m_busy, m_active, m_led);
      end
      if (ack != '0) order.push_back(ack_index(ack));
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (g >= order.size() || order[g] != exp_order[g]) begin
        failures++;
        $display("FAIL rr_order grant=%0d got=%0d exp=%0d", g,
                 (g < order.size()) ? order[g] : -1, exp_order[g]);
      end
    end
    req = '0;
  endtask

  task automatic test_zero_code();
    do_reset();
    code = {4'($urandom_range(1, 3)), 4'd0, 4'd0, 4'd0};
    req  = 4'b1100;
    tick();
    checks++;
    if ({ack, busy, ledpin} !== {4'b0100, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL zero_grant ack/busy/led got=%b/%b/%b exp=0100/0/0", ack, busy, ledpin);
    end
    req = req & ~m_ack;
    tick();
    checks++;
    if (ack !== 4'b1000) begin
      failures++;
      $display("FAIL zero_next_grant got=%b exp=1000", ack);
    end
    req = req & ~m_ack;
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if ({ack, busy, active_id, ledpin} !== {m_ack, m_busy, m_active, m_led}) begin
        failures++;
        $display("FAIL zero_code cyc=%0d ack/busy/id/led got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 c, ack, busy, active_id, ledpin, m_ack, m_busy, m_active, m_led);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    code = {4'd0, 4'd0, 4'($urandom_range(2, 4)), 4'd0};
    req  = 4'b0010;
    tick();
    tick();
    checks++;
    if (ledpin !== 1'b1 || active_id !== 2'd1) begin
      failures++;
      $display("FAIL async_pre led/id got=%b/%0d exp=1/1", ledpin, active_id);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ack, busy, active_id, ledpin} !== 8'b0) begin
      failures++;
      $display("FAIL async_immediate ack/busy/id/led got=%b/%b/%0d/%b exp=0/0/0/0",
               ack, busy, active_id, ledpin);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if ({ack, busy, active_id, ledpin} !== {m_ack, m_busy, m_active, m_led}) begin
        failures++;
        $display("FAIL async_replay cyc=%0d ack/busy/id/led got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 c, ack, busy, active_id, ledpin, m_ack, m_busy, m_active, m_led);
      end
      if (c == 0) begin
        checks++;
        if (ack !== 4'b0010) begin
          failures++;
          $display("FAIL async_regrant got=%b exp=0010", ack);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
      end
      code = 16'($urandom);
      code = code & 16'h3333;
      tick();
      checks++;
      if ({ack, busy, active_id, ledpin} !== {m_ack, m_busy, m_active, m_led}) begin
        failures++;
        $display("FAIL random cyc=%0d ack/busy/id/led got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 c, ack, busy, active_id, ledpin, m_ack, m_busy, m_active, m_led);
      end
      req = req & ~m_ack;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    code  = '0;
    test_reset();
    test_single_code();
    test_simultaneous();
    test_round_robin();
    test_zero_code();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
